uc_ctrl: RTL and testbench

- Control unit for the simple CPU. Consumes `opcode`, `zero` and `carry` from the `microc` datapath.
- Produces the datapath control word (`s_skip`, `s_inc`, `s_inm`, `we`, `alu_op`) that the datapath bench currently drives by hand.
- Adds a run/halt state machine, a sticky illegal-opcode flag and saturating retired/skipped instruction counters for debug.
- Instantiated beside `microc` in the `cpu` top level; all control outputs connect 1:1 to the same-named `microc` ports.

---
 rtl/uc_pkg.sv | 34 +++
 rtl/uc_sat_counter.sv | 29 ++
 rtl/uc_ctrl.sv | 122 ++++++++++++
 tb/tb_uc_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uc_pkg
// Purpose  : Shared constants and types for the uc_ctrl control unit:
//            opcode classes, ALU operation codes and the run/halt state.
// Revision : 1.0 - initial release
// ============================================================================
package uc_pkg;

  // Opcode classes, matched against opcode[5:2] unless noted
  localparam logic [3:0] OP_LI     = 4'b0000;
  localparam logic [3:0] OP_SKIPNE = 4'b0001;
  localparam logic [3:0] OP_SKIPGT = 4'b0010;
  localparam logic [3:0] OP_MOV    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  // JR is matched on opcode[5:4] only
  localparam logic [1:0] OP_JR_HI  = 2'b10;
  // HALT is matched on the full opcode
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // ALU operation select
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_PASSA = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : uc_sat_counter
// Purpose  : W-bit up counter with enable that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module uc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  // Count enabled cycles, holding at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en && (q != MAX_VAL)) begin
      q <= q + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uc_ctrl
// Purpose  : Control unit for the microc datapath. Decodes the current
//            opcode into the datapath control word, tracks run/halt state,
//            flags unassigned opcodes and counts retired/skipped instructions.
// Revision : 1.0 - initial release
// ============================================================================
module uc_ctrl
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             carry,
  output logic             s_skip,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] skipped
);

  state_t state;
  logic   is_halt;
  logic   is_illegal;
  logic   run_cycle;
  logic   skip_taken;

  // Combinational decode; flags feed only s_skip, so there is no loop back
  // through the ALU. Reset and S_HALT override the opcode.
  always_comb begin
    s_skip     = 1'b0;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we         = 1'b0;
    alu_op     = ALU_PASSB;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (reset) begin
      // NOP forcing already set by the defaults
    end else if (state == S_HALT) begin
      s_inc = 1'b0;
    end else if (opcode[5:4] == OP_JR_HI) begin
      s_inc = 1'b0;
    end else if (opcode == OP_HALT) begin
      // Target is the HALT's own address, so the PC holds
      s_inc   = 1'b0;
      is_halt = 1'b1;
    end else begin
      case (opcode[5:2])
        OP_LI: begin
          s_inm = 1'b1;
          we    = 1'b1;
        end
        OP_SKIPNE: begin
          alu_op = ALU_SUB;
          s_skip = ~zero;
        end
        OP_SKIPGT: begin
          alu_op = ALU_SUB;
          s_skip = ~zero & ~carry;
        end
        OP_MOV: begin
          alu_op = ALU_PASSA;
          we     = 1'b1;
        end
        OP_ADD: begin
          alu_op = ALU_ADD;
          we     = 1'b1;
        end
        OP_SUB: begin
          alu_op = ALU_SUB;
          we     = 1'b1;
        end
        default: is_illegal = 1'b1;
      endcase
    end
  end

  // Run/halt state with registered halted and sticky illegal flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else if (state == S_RUN) begin
      if (is_halt) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
      if (is_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

  assign run_cycle  = ~reset & (state == S_RUN);
  assign skip_taken = run_cycle & s_skip & s_inc;

  uc_sat_counter #(.W(CNT_W)) u_retired (
    .clk   (clk),
    .reset (reset),
    .en    (run_cycle),
    .q     (retired)
  );

  uc_sat_counter #(.W(CNT_W)) u_skipped (
    .clk   (clk),
    .reset (reset),
    .en    (skip_taken),
    .q     (skipped)
  );

endmodule
`default_nettype wire

// File: tb/tb_uc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_ctrl
// Purpose  : Directed self-checking bench for uc_ctrl (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uc_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             carry;
  logic             s_skip;
  logic             s_inc;
  logic             s_inm;
  logic             we;
  logic [2:0]       alu_op;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] skipped;

  int errors = 0;
  int checks = 0;

  uc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .zero    (zero),
    .carry   (carry),
    .s_skip  (s_skip),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we      (we),
    .alu_op  (alu_op),
    .halted  (halted),
    .illegal (illegal),
    .retired (retired),
    .skipped (skipped)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    opcode = 6'b000000; zero = 1'b0; carry = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; carry = 1'b0;
    cyc(); cyc();
    #1;
    checks++; if ({we, s_inc, s_skip, s_inm, alu_op} !== 7'b0100000) begin
      errors++; $display("FAIL reset_nop: got we/inc/skip/inm/alu=%b want 0100000", {we, s_inc, s_skip, s_inm, alu_op});
    end
    checks++; if ({halted, illegal, retired, skipped} !== 10'd0) begin
      errors++; $display("FAIL reset_regs: got halted=%b illegal=%b retired=%0d skipped=%0d want all 0", halted, illegal, retired, skipped);
    end
    reset = 1'b0;
    #1;
    checks++; if ({we, s_inm, alu_op, s_inc, s_skip} !== 7'b1100010) begin
      errors++; $display("FAIL li_decode: got we/inm/alu/inc/skip=%b want 1100010", {we, s_inm, alu_op, s_inc, s_skip});
    end
    cyc();
    checks++; if (retired !== 4'd1) begin
      errors++; $display("FAIL li_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_skipne();
    do_reset();
    opcode = 6'b000100; zero = 1'b0;
    #1;
    checks++; if ({s_skip, s_inc, alu_op, we, s_inm} !== 7'b1101100) begin
      errors++; $display("FAIL skipne_taken: got skip/inc/alu/we/inm=%b want 1101100", {s_skip, s_inc, alu_op, we, s_inm});
    end
    cyc();
    checks++; if (skipped !== 4'd1 || retired !== 4'd1) begin
      errors++; $display("FAIL skipne_count: got skipped=%0d retired=%0d want 1 1", skipped, retired);
    end
    zero = 1'b1;
    #1;
    checks++; if (s_skip !== 1'b0 || s_inc !== 1'b1) begin
      errors++; $display("FAIL skipne_not_taken: got skip=%b inc=%b want 0 1", s_skip, s_inc);
    end
    cyc();
    checks++; if (skipped !== 4'd1 || retired !== 4'd2) begin
      errors++; $display("FAIL skipne_hold: got skipped=%0d retired=%0d want 1 2", skipped, retired);
    end
  endtask

  task automatic test_skipgt_alu_jr();
    logic [3:0] exp_skip;
    do_reset();
    exp_skip = 4'b0001;  // index {zero,carry}: only 00 skips
    opcode = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      {zero, carry} = 2'(i);
      #1;
      checks++; if (s_skip !== exp_skip[i] || alu_op !== 3'b011 || we !== 1'b0) begin
        errors++; $display("FAIL skipgt_zc%0d: got skip=%b alu=%b we=%b want %b 011 0", i, s_skip, alu_op, we, exp_skip[i]);
      end
      cyc();
    end
    checks++; if (skipped !== 4'd1 || retired !== 4'd4) begin
      errors++; $display("FAIL skipgt_count: got skipped=%0d retired=%0d want 1 4", skipped, retired);
    end
    zero = 1'b0; carry = 1'b0;
    opcode = 6'b010011;  // ADD with arbitrary low bits
    #1;
    checks++; if ({alu_op, we, s_inm, s_inc, s_skip} !== 7'b0101010) begin
      errors++; $display("FAIL add_decode: got alu/we/inm/inc/skip=%b want 0101010", {alu_op, we, s_inm, s_inc, s_skip});
    end
    opcode = 6'b001101;  // MOV
    #1;
    checks++; if (alu_op !== 3'b001 || we !== 1'b1 || s_inm !== 1'b0) begin
      errors++; $display("FAIL mov_decode: got alu=%b we=%b inm=%b want 001 1 0", alu_op, we, s_inm);
    end
    opcode = 6'b010110;  // SUB
    #1;
    checks++; if (alu_op !== 3'b011 || we !== 1'b1) begin
      errors++; $display("FAIL sub_decode: got alu=%b we=%b want 011 1", alu_op, we);
    end
    opcode = 6'b100000;  // JR
    #1;
    checks++; if ({s_inc, we, s_skip, alu_op} !== 6'b000000) begin
      errors++; $display("FAIL jr_decode: got inc/we/skip/alu=%b want 000000", {s_inc, we, s_skip, alu_op});
    end
    opcode = 6'b101111;  // JR, upper end of its range
    #1;
    checks++; if (s_inc !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL jr_hi_decode: got inc=%b we=%b want 0 0", s_inc, we);
    end
    cyc();
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL jr_state: got halted=%b illegal=%b want 0 0", halted, illegal);
    end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 6'b111111;
    #1;
    checks++; if (s_inc !== 1'b0 || we !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_decode: got inc=%b we=%b halted=%b want 0 0 0", s_inc, we, halted);
    end
    cyc();
    checks++; if (halted !== 1'b1 || retired !== 4'd1) begin
      errors++; $display("FAIL halt_enter: got halted=%b retired=%0d want 1 1", halted, retired);
    end
    opcode = 6'b000000;
    #1;
    checks++; if ({we, s_inc, s_skip} !== 3'b000) begin
      errors++; $display("FAIL halt_li: got we/inc/skip=%b want 000", {we, s_inc, s_skip});
    end
    cyc();
    opcode = 6'b000100; zero = 1'b0;
    #1;
    checks++; if ({we, s_inc, s_skip} !== 3'b000) begin
      errors++; $display("FAIL halt_skipne: got we/inc/skip=%b want 000", {we, s_inc, s_skip});
    end
    cyc();
    checks++; if (retired !== 4'd1 || skipped !== 4'd0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_frozen: got retired=%0d skipped=%0d halted=%b want 1 0 1", retired, skipped, halted);
    end
    reset = 1'b1;
    #1;
    checks++; if ({we, s_inc, s_skip} !== 3'b010) begin
      errors++; $display("FAIL halt_reset_nop: got we/inc/skip=%b want 010", {we, s_inc, s_skip});
    end
    cyc();
    reset = 1'b0;
    checks++; if (halted !== 1'b0 || retired !== 4'd0 || skipped !== 4'd0) begin
      errors++; $display("FAIL halt_reset: got halted=%b retired=%0d skipped=%0d want 0 0 0", halted, retired, skipped);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ill_ops [3];
    ill_ops[0] = 6'b011000;
    ill_ops[1] = 6'b110101;
    ill_ops[2] = 6'b111110;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      opcode = ill_ops[k];
      #1;
      checks++; if ({we, s_inc, s_skip, s_inm, alu_op, illegal} !== 8'b01000000) begin
        errors++; $display("FAIL illegal_nop_%b: got we/inc/skip/inm/alu/ill=%b want 01000000", ill_ops[k], {we, s_inc, s_skip, s_inm, alu_op, illegal});
      end
      cyc();
      checks++; if (illegal !== 1'b1 || retired !== 4'd1 || halted !== 1'b0) begin
        errors++; $display("FAIL illegal_set_%b: got illegal=%b retired=%0d halted=%b want 1 1 0", ill_ops[k], illegal, retired, halted);
      end
    end
    opcode = 6'b000000;
    cyc(); cyc();
    opcode = 6'b111111;
    cyc();
    opcode = 6'b000000;
    cyc();
    checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: got illegal=%b halted=%b want 1 1", illegal, halted);
    end
    do_reset();
    checks++; if (illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %b want 0", illegal);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    opcode = 6'b000000;
    for (int i = 0; i < 20; i++) cyc();
    checks++; if (retired !== 4'd15 || skipped !== 4'd0) begin
      errors++; $display("FAIL retired_sat: got retired=%0d skipped=%0d want 15 0", retired, skipped);
    end
    do_reset();
    opcode = 6'b000100; zero = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    checks++; if (skipped !== 4'd15 || retired !== 4'd15) begin
      errors++; $display("FAIL skipped_sat: got skipped=%0d retired=%0d want 15 15", skipped, retired);
    end
  endtask

  initial begin
    test_reset();
    test_skipne();
    test_skipgt_alu_jr();
    test_halt();
    test_illegal();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
